aes_enc_core: RTL and testbench



---
 rtl/aes_pkg.sv | 57 +++++
 rtl/sbox_fwd.sv | 32 +++
 rtl/aes_enc_core.sv | 103 ++++++++++
 tb/tb_aes_enc_core.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, round-constant table and GF(2^8) helpers
// for the encrypt core.
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int NR      = 10;

  typedef enum logic {
    IDLE,
    RUN
  } st_e;

  function automatic logic [7:0] rcon(
    input logic [3:0] r
  );
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Column bytes are a0 (top row) .. a3, packed msb-first.
  function automatic logic [31:0] mix_column(
    input logic [31:0] c
  );
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/sbox_fwd.sv
// Forward AES S-box, purely combinational byte lookup.
// Row 0 of the table is the top 128 bits of tbl.
module sbox_fwd (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] idx;

  assign idx = ~a;
  assign y   = TBL[{idx, 3'b000} +: 8];

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryptor: one round per clock, round keys
// expanded on the fly from the previous round key.
module aes_enc_core
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] din,
  input  logic [STATE_W-1:0] key,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] dout
);

  st_e                fsm;
  logic [3:0]         rnd;
  logic [STATE_W-1:0] st;
  logic [STATE_W-1:0] rkey;

  logic [STATE_W-1:0] sb;
  logic [STATE_W-1:0] sr;
  logic [STATE_W-1:0] mc;
  logic [STATE_W-1:0] rk_next;
  logic [31:0]        w3rot;
  logic [31:0]        sw;
  logic [31:0]        t;
  logic [31:0]        n0, n1, n2, n3;

  for (genvar i = 0; i < 16; i++) begin : g_sub
    sbox_fwd u_sb (
      .a (st[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  // Byte (row r, col c) takes the byte from column c+r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(4*c+r) -: 8] =
        sb[127-8*(4*((c+r)%4)+r) -: 8];
    end
    assign mc[127-32*c -: 32] =
      mix_column(sr[127-32*c -: 32]);
  end

  assign w3rot = {rkey[23:0], rkey[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_sw
    sbox_fwd u_sw (
      .a (w3rot[31-8*j -: 8]),
      .y (sw[31-8*j -: 8])
    );
  end

  assign t  = sw ^ {rcon(rnd), 24'h0};
  assign n0 = rkey[127:96] ^ t;
  assign n1 = rkey[95:64]  ^ n0;
  assign n2 = rkey[63:32]  ^ n1;
  assign n3 = rkey[31:0]   ^ n2;

  assign rk_next = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm  <= IDLE;
      rnd  <= '0;
      st   <= '0;
      rkey <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dout <= '0;
    end else begin
      done <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (start) begin
            st   <= din ^ key;
            rkey <= key;
            rnd  <= 4'd1;
            busy <= 1'b1;
            fsm  <= RUN;
          end
        end
        RUN: begin
          if (rnd == 4'(NR)) begin
            dout <= sr ^ rk_next;
            done <= 1'b1;
            busy <= 1'b0;
            rnd  <= '0;
            fsm  <= IDLE;
          end else begin
            st   <= mc ^ rk_next;
            rkey <= rk_next;
            rnd  <= rnd + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_core.sv
// Self-checking bench for aes_enc_core using FIPS-197 vectors and
// a queue of expected ciphertexts.
module tb_aes_enc_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] din;
  logic [127:0] key;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  int nvec = 0;
  int nerr = 0;

  logic [127:0] exp_q[$];

  localparam logic [127:0] C1_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_D = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_E = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_D  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_E  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_E  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  aes_enc_core dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .key   (key),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called #1 after an edge with busy low; returns #1 after accept edge.
  task automatic launch(
    input logic [127:0] d,
    input logic [127:0] k,
    input logic [127:0] e
  );
    start = 1'b1;
    din   = d;
    key   = k;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    din   = rnd128();
    key   = rnd128();
  endtask

  // Counts edges after the accept edge until done; pulses a stray
  // start with junk data at edge counts p1/p2 when non-zero.
  task automatic wait_done(
    input  int p1,
    input  int p2,
    output int lat
  );
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (lat == p1 || lat == p2) begin
        start = 1'b1;
        din   = rnd128();
        key   = rnd128();
      end
    end while (!done && lat < 40);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    din   = 'x;
    key   = 'x;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL reset_busy got %0b want 0", busy);
    end
    nvec++;
    if (done !== 1'b0) begin
      nerr++;
      $display("FAIL reset_done got %0b want 0", done);
    end
    nvec++;
    if (dout !== 128'h0) begin
      nerr++;
      $display("FAIL reset_dout got %h want 0", dout);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (dout !== 128'h0) begin
      nerr++;
      $display("FAIL idle_x_dout got %h want 0", dout);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL idle_busy got %0b want 0", busy);
    end
    din = '0;
    key = '0;
  endtask

  task automatic test_vector(
    input string          nm,
    input logic [127:0]   d,
    input logic [127:0]   k,
    input logic [127:0]   e,
    input int             p1,
    input int             p2
  );
    int lat;
    logic [127:0] x;
    launch(d, k, e);
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL %s_busy got %0b want 1", nm, busy);
    end
    wait_done(p1, p2, lat);
    x = exp_q.pop_front();
    nvec++;
    if (lat !== 10) begin
      nerr++;
      $display("FAIL %s_latency got %0d want 10", nm, lat);
    end
    nvec++;
    if (dout !== x) begin
      nerr++;
      $display("FAIL %s_dout got %h want %h", nm, dout, x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [127:0] x;
    launch(C1_D, C1_K, C1_E);
    wait_done(0, 0, lat);
    x = exp_q.pop_front();
    nvec++;
    if (dout !== x || lat !== 10) begin
      nerr++;
      $display("FAIL b2b_first got %h lat %0d want %h lat 10",
               dout, lat, x);
    end
    launch(B_D, B_K, B_E);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_accept got done %0b busy %0b want 0 1",
               done, busy);
    end
    wait_done(0, 0, lat);
    x = exp_q.pop_front();
    nvec++;
    if (lat !== 10) begin
      nerr++;
      $display("FAIL b2b_latency got %0d want 10", lat);
    end
    nvec++;
    if (dout !== x) begin
      nerr++;
      $display("FAIL b2b_second got %h want %h", dout, x);
    end
    @(posedge clk);
    #1;
    nvec++;
    if (done !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_done_drop got %0b want 0", done);
    end
  endtask

  task automatic test_reset_mid();
    launch(C1_D, C1_K, C1_E);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL midrst_ctl got busy %0b done %0b want 0 0",
               busy, done);
    end
    nvec++;
    if (dout !== 128'h0) begin
      nerr++;
      $display("FAIL midrst_dout got %h want 0", dout);
    end
    repeat (12) begin
      @(posedge clk);
      #1;
      nvec++;
      if (done !== 1'b0) begin
        nerr++;
        $display("FAIL midrst_nodone got %0b want 0", done);
      end
    end
    test_vector("midrst_rerun", C1_D, C1_K, C1_E, 0, 0);
  endtask

  task automatic test_zero_hold();
    test_vector("zero", 128'h0, 128'h0, Z_E, 0, 0);
    din = rnd128();
    key = rnd128();
    repeat (5) @(posedge clk);
    #1;
    nvec++;
    if (dout !== Z_E) begin
      nerr++;
      $display("FAIL zero_hold got %h want %h", dout, Z_E);
    end
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL zero_idle got done %0b busy %0b want 0 0",
               done, busy);
    end
  endtask

  initial begin
    test_reset();
    test_vector("fips_c1", C1_D, C1_K, C1_E, 0, 0);
    test_vector("fips_b", B_D, B_K, B_E, 0, 0);
    test_vector("ignore_start", C1_D, C1_K, C1_E, 3, 7);
    test_back_to_back();
    test_reset_mid();
    test_zero_hold();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
